div_sequencer: RTL and testbench

- Multi-cycle restoring divider controller for the MIPS ALU (DIV/DIVU, HI/LO results).
- Sequences the team's 32-bit Subtractor module once per cycle for the trial subtraction.
- Holds quotient and remainder until the next operation, with a start/busy/done handshake to the pipeline stall logic.

---
 rtl/div_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_div_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// -----------------------------------------------------------------------------
// div_sequencer
//
// Multi-cycle restoring divider controller for the MIPS ALU (DIV/DIVU).
// It produces one quotient bit per cycle. Each trial subtraction goes through
// the shared 32-bit subtractor. The quotient (LO) and remainder (HI) stay on
// the outputs until the next accepted operation completes.
//
// Optional feature macro: SIGNED_DIV_EN
//   undefined : unsigned only, states IDLE/RUN/DONE, 33-cycle latency.
//   defined   : adds the is_signed input and a FIXUP state (34-cycle latency).
//               The loop divides magnitudes. FIXUP then applies the signs.
//
// Parameters:
//   DIV0_QUOTIENT  quotient value reported on a divide-by-zero.
//
// Ports:
//   clk          in   1   rising-edge clock
//   rst          in   1   asynchronous, active-high reset
//   start        in   1   request pulse, only honoured in IDLE
//   dividend     in  32   numerator, captured on an accepted start
//   divisor      in  32   denominator, captured on an accepted start
//   is_signed    in   1   (SIGNED_DIV_EN only) signed operation select
//   busy         out  1   high while the iteration loop is running
//   done         out  1   one-cycle pulse; results valid from this cycle on
//   quotient     out 32   LO result, held until the next operation completes
//   remainder    out 32   HI result, held until the next operation completes
//   div_by_zero  out  1   set with done when the divisor was zero
// -----------------------------------------------------------------------------

// 32-bit subtractor: returns a - b and the borrow, which is set when a < b.
module subtractor (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] diff_o,
    output logic        borrow_o
);

    // 33-bit difference; the top bit is the borrow out of bit 31.
    always_comb begin
        {borrow_o, diff_o} = {1'b0, a_i} - {1'b0, b_i};
    end

endmodule

module div_sequencer #(
    parameter logic [31:0] DIV0_QUOTIENT = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
`ifdef SIGNED_DIV_EN
    input  logic        is_signed,
`endif
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_FIXUP = 2'd3
    } state_t;

    state_t      state_q;
    logic [4:0]  count_q;
    logic [31:0] rem_q;      // partial remainder R
    logic [31:0] quo_q;      // dividend shifting out / quotient shifting in (Q)
    logic [31:0] dvsr_q;     // captured divisor (magnitude in signed mode)
    logic        div0_q;     // pending divide-by-zero flag for the DONE state

    logic [32:0] s_s;        // {R, Q[31]}: the shifted partial remainder
    logic [31:0] trial_s;
    logic        borrow_s;
    logic        take_s;
    logic [31:0] rem_d;
    logic [31:0] quo_d;
    logic [31:0] dividend_mag_s;
    logic [31:0] divisor_mag_s;

`ifdef SIGNED_DIV_EN
    logic        neg_quo_q;  // operand signs differ: negate the quotient
    logic        neg_rem_q;  // dividend negative: negate the remainder

    // Magnitudes of the operands. The most negative value maps to 32'h80000000,
    // which is the correct unsigned magnitude.
    always_comb begin
        if (is_signed && dividend[31]) begin
            dividend_mag_s = 32'd0 - dividend;
        end else begin
            dividend_mag_s = dividend;
        end
        if (is_signed && divisor[31]) begin
            divisor_mag_s = 32'd0 - divisor;
        end else begin
            divisor_mag_s = divisor;
        end
    end
`else
    // Unsigned only: the operands go to the loop unchanged.
    always_comb begin
        dividend_mag_s = dividend;
        divisor_mag_s  = divisor;
    end
`endif

    assign s_s = {rem_q, quo_q[31]};

    subtractor u_sub (
        .a_i      (s_s[31:0]),
        .b_i      (dvsr_q),
        .diff_o   (trial_s),
        .borrow_o (borrow_s)
    );

    // If the shifted-out bit is set, S is at least 2^32 and so exceeds any
    // divisor. The wrapped 32-bit trial difference is still the true result,
    // because S is always less than 2*divisor.
    assign take_s = s_s[32] | ~borrow_s;

    // One restoring-division step: keep the trial difference or restore S.
    always_comb begin
        if (take_s) begin
            rem_d = trial_s;
            quo_d = {quo_q[30:0], 1'b1};
        end else begin
            rem_d = s_s[31:0];
            quo_d = {quo_q[30:0], 1'b0};
        end
    end

    // Control FSM with the datapath registers and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= 5'd0;
            rem_q       <= 32'd0;
            quo_q       <= 32'd0;
            dvsr_q      <= 32'd0;
            div0_q      <= 1'b0;
`ifdef SIGNED_DIV_EN
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
`endif
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= 32'd0;
            remainder   <= 32'd0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // Ignore a start that coincides with the done pulse. The
                    // pipeline must issue its next request after done.
                    if (start && !done) begin
                        div_by_zero <= 1'b0;
                        if (divisor == 32'd0) begin
                            // No loop: stage the fixed results, publish them
                            // in DONE.
                            quo_q   <= DIV0_QUOTIENT;
                            rem_q   <= dividend;
                            div0_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            rem_q   <= 32'd0;
                            quo_q   <= dividend_mag_s;
                            dvsr_q  <= divisor_mag_s;
                            count_q <= 5'd0;
                            div0_q  <= 1'b0;
                            busy    <= 1'b1;
`ifdef SIGNED_DIV_EN
                            neg_quo_q <= is_signed & (dividend[31] ^ divisor[31]);
                            neg_rem_q <= is_signed & dividend[31];
`endif
                            state_q <= ST_RUN;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    rem_q   <= rem_d;
                    quo_q   <= quo_d;
                    count_q <= count_q + 5'd1;
                    if (count_q == 5'd31) begin
`ifdef SIGNED_DIV_EN
                        state_q <= ST_FIXUP;
`else
                        busy    <= 1'b0;
                        state_q <= ST_DONE;
`endif
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
`ifdef SIGNED_DIV_EN
                ST_FIXUP: begin
                    // Quotient follows the XOR of the signs. The remainder
                    // follows the sign of the dividend.
                    if (neg_quo_q) begin
                        quo_q <= 32'd0 - quo_q;
                    end else begin
                        quo_q <= quo_q;
                    end
                    if (neg_rem_q) begin
                        rem_q <= 32'd0 - rem_q;
                    end else begin
                        rem_q <= rem_q;
                    end
                    busy    <= 1'b0;
                    state_q <= ST_DONE;
                end
`endif
                ST_DONE: begin
                    // The only place where the visible results change.
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    quotient    <= quo_q;
                    remainder   <= rem_q;
                    div_by_zero <= div0_q;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// -----------------------------------------------------------------------------
// tb_div_sequencer
//
// Scoreboard bench for div_sequencer. The stimulus tasks push the expected
// result and the expected done cycle for each operation. The monitor pops one
// entry on every done pulse and compares it. A done pulse with nothing queued
// counts as a miscompare.
// -----------------------------------------------------------------------------
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;
`ifdef SIGNED_DIV_EN
    logic        is_signed;
    localparam int LAT = 34;
`else
    localparam int LAT = 33;
`endif
    localparam int BUSY_CYC = LAT - 1;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc      = 0;
    int   vectors  = 0;
    int   fails    = 0;
    int   done_cnt = 0;
    int   busy_cnt = 0;

    always #5 clk = ~clk;

    div_sequencer #(.DIV0_QUOTIENT(32'hFFFFFFFF)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
`ifdef SIGNED_DIV_EN
        .is_signed   (is_signed),
`endif
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: count busy cycles and check every done pulse against the queue.
    always @(negedge clk) begin
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                vectors++;
                fails++;
                $display("FAIL unexpected_done: done pulse with q=%h r=%h, expected no pulse", quotient, remainder);
            end else begin
                mon_e = sb.pop_front();
                check("quotient", quotient, mon_e.q);
                check("remainder", remainder, mon_e.r);
                check("div_by_zero", {31'd0, div_by_zero}, {31'd0, mon_e.dz});
                check("done_cycle", cyc, mon_e.cyc);
            end
        end
    end

    // Pulse start for one cycle. Return the cycle number of the accepting edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, output int e0);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
`ifdef SIGNED_DIV_EN
        is_signed = s;
`endif
        @(posedge clk);
        #1;
        e0       = cyc;
        start    = 1'b0;
        dividend = 32'hDEADBEEF;
        divisor  = 32'h00000003;
`ifdef SIGNED_DIV_EN
        is_signed = ~s;
`endif
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            vectors++;
            fails++;
            $display("FAIL timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [31:0] eq, input logic [31:0] er, input logic edz,
                          input int lat, input int ebusy);
        int e0;
        busy_cnt = 0;
        issue(a, b, s, e0);
        sb.push_back('{eq, er, edz, e0 + lat});
        wait_idle();
        check("busy_cycles", busy_cnt, ebusy);
    endtask

    initial begin
        int e0;
        int d0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
`ifdef SIGNED_DIV_EN
        is_signed = 1'b0;
`endif
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        check("rst_div0", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors: {dividend, divisor} -> {quotient, remainder}.
        run_op(32'd100,        32'd7,        1'b0, 32'd14,         32'd2,   1'b0, LAT, BUSY_CYC);
        run_op(32'hFFFFFFFF,   32'd1,        1'b0, 32'hFFFFFFFF,   32'd0,   1'b0, LAT, BUSY_CYC);
        repeat (3) @(negedge clk);
        check("hold_quotient", quotient, 32'hFFFFFFFF);
        run_op(32'd5,          32'd9,        1'b0, 32'd0,          32'd5,   1'b0, LAT, BUSY_CYC);
        run_op(32'h00001234,   32'd0,        1'b0, 32'hFFFFFFFF,   32'h1234, 1'b1, 1,  0);
        run_op(32'hFFFFFFFF,   32'hFFFFFFFF, 1'b0, 32'd1,          32'd0,   1'b0, LAT, BUSY_CYC);
        run_op(32'h80000000,   32'd3,        1'b0, 32'h2AAAAAAA,   32'd2,   1'b0, LAT, BUSY_CYC);
        run_op(32'd123456789,  32'd10000,    1'b0, 32'd12345,      32'd6789, 1'b0, LAT, BUSY_CYC);
        run_op(32'd0,          32'd5,        1'b0, 32'd0,          32'd0,   1'b0, LAT, BUSY_CYC);

        // A second start while busy must be ignored.
        d0 = done_cnt;
        issue(32'd100, 32'd7, 1'b0, e0);
        sb.push_back('{32'd14, 32'd2, 1'b0, e0 + LAT});
        repeat (9) @(negedge clk);
        start = 1'b1; dividend = 32'd50; divisor = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();
        repeat (40) @(negedge clk);
        check("one_done_busy_start", done_cnt - d0, 32'd1);

        // A start in the same cycle as done must be ignored.
        d0 = done_cnt;
        issue(32'd100, 32'd7, 1'b0, e0);
        sb.push_back('{32'd14, 32'd2, 1'b0, e0 + LAT});
        for (int i = 0; i < 60 && done !== 1'b1; i++) @(negedge clk);
        start = 1'b1; dividend = 32'd9; divisor = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();
        repeat (40) @(negedge clk);
        check("one_done_start_at_done", done_cnt - d0, 32'd1);

        // Reset mid-run: outputs clear and no done pulse follows.
        d0 = done_cnt;
        issue(32'd100, 32'd7, 1'b0, e0);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_quotient", quotient, 32'd0);
        check("midrst_remainder", remainder, 32'd0);
        check("midrst_div0", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("midrst_no_done", done_cnt - d0, 32'd0);
        run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, LAT, BUSY_CYC);

`ifdef SIGNED_DIV_EN
        run_op(32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, LAT, BUSY_CYC);
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0,        1'b0, LAT, BUSY_CYC);
        run_op(32'hFFFFFFF9, 32'd0,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 1,   0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
